// File: rtl/buffer_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buffer_wr_arbiter
// Brief    : Round-robin burst arbiter for the bootloader buffer write port.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_wr_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_BURST  = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  req0_valid_i,
  input  logic [WORD_WIDTH-1:0] req0_data_i,
  input  logic                  req0_last_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [WORD_WIDTH-1:0] req1_data_i,
  input  logic                  req1_last_i,
  output logic                  req1_ready_o,
  output logic                  buf_valid_o,
  output logic [WORD_WIDTH-1:0] buf_data_o,
  input  logic                  buf_ready_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam int c_CNT_W  = $clog2(MAX_BURST + 1);
  localparam int c_IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_ONE   = c_IDLE_W'(1);
  localparam logic [c_CNT_W-1:0]  c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_IDLE_W-1:0] c_TO_LAST    = (TIMEOUT > 0) ? c_IDLE_W'(TIMEOUT - 1) : '0;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_sel;
  logic                r_prio;
  logic [1:0]          r_grant;
  logic                r_busy;
  logic [c_CNT_W-1:0]  r_burst_cnt;
  logic [c_IDLE_W-1:0] r_idle_cnt;

  logic                  w_active;
  logic                  w_valid;
  logic                  w_last;
  logic [WORD_WIDTH-1:0] w_data;
  logic                  w_xfer;
  logic                  w_pick;
  logic                  w_timeout;
  logic                  w_release;

  // Gating with reset_i keeps the stream quiet during the reset cycle itself,
  // so no word is accepted from a burst that is about to be abandoned.
  assign w_active = (r_state == S_GRANT) && !reset_i;
  assign w_valid  = r_sel ? req1_valid_i : req0_valid_i;
  assign w_last   = r_sel ? req1_last_i  : req0_last_i;
  assign w_data   = r_sel ? req1_data_i  : req0_data_i;

  assign buf_valid_o  = w_active & en_i & w_valid;
  assign buf_data_o   = w_active ? w_data : '0;
  assign req0_ready_o = w_active & ~r_sel & en_i & buf_ready_i;
  assign req1_ready_o = w_active &  r_sel & en_i & buf_ready_i;
  assign w_xfer       = buf_valid_o & buf_ready_i;

  // 1 selects req1: the priority requester wins, otherwise whoever is valid.
  assign w_pick = r_prio ? req1_valid_i : ~req0_valid_i;

  assign w_timeout = (TIMEOUT != 0) && en_i && !w_valid && (r_idle_cnt == c_TO_LAST);
  assign w_release = (w_xfer && (w_last || (r_burst_cnt == c_BURST_LAST))) || w_timeout;

  assign grant_o = r_grant;
  assign busy_o  = r_busy;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_prio      <= 1'b0;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else if (en_i) begin
      if (r_state == S_IDLE) begin
        if (req0_valid_i || req1_valid_i) begin
          r_state <= S_GRANT;
          r_sel   <= w_pick;
          r_grant <= w_pick ? 2'b10 : 2'b01;
          r_busy  <= 1'b1;
        end
      end else if (w_release) begin
        r_state     <= S_IDLE;
        r_grant     <= 2'b00;
        r_busy      <= 1'b0;
        r_prio      <= ~r_sel;
        r_burst_cnt <= '0;
        r_idle_cnt  <= '0;
      end else begin
        if (w_xfer) begin
          r_burst_cnt <= r_burst_cnt + c_CNT_ONE;
        end
        // A stalled-but-valid producer is not idle, even with the buffer full.
        if (w_valid) begin
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer_wr_arbiter.sv
`default_nettype none
// Directed bench for buffer_wr_arbiter: burst ordering, max-burst split,
// back-pressure, timeout, reset/enable behaviour and single-word bursts.
module tb_buffer_wr_arbiter;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } word_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       en_i = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_last = 1'b0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_last = 1'b0;
  logic       buf_ready = 1'b1;

  logic       buf_valid_a, req0_ready_a, req1_ready_a, busy_a;
  logic [7:0] buf_data_a;
  logic [1:0] grant_a;
  logic       buf_valid_b, req0_ready_b, req1_ready_b, busy_b;
  logic [7:0] buf_data_b;
  logic [1:0] grant_b;
  logic       buf_valid_c, req0_ready_c, req1_ready_c, busy_c;
  logic [7:0] buf_data_c;
  logic [1:0] grant_c;

  word_t      q0[$];
  word_t      q1[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  bit         manual = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  buffer_wr_arbiter #(.WORD_WIDTH(8), .MAX_BURST(64), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last),
    .req0_ready_o(req0_ready_a),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last),
    .req1_ready_o(req1_ready_a),
    .buf_valid_o(buf_valid_a), .buf_data_o(buf_data_a), .buf_ready_i(buf_ready),
    .grant_o(grant_a), .busy_o(busy_a)
  );

  buffer_wr_arbiter #(.WORD_WIDTH(8), .MAX_BURST(64), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last),
    .req0_ready_o(req0_ready_b),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last),
    .req1_ready_o(req1_ready_b),
    .buf_valid_o(buf_valid_b), .buf_data_o(buf_data_b), .buf_ready_i(buf_ready),
    .grant_o(grant_b), .busy_o(busy_b)
  );

  buffer_wr_arbiter #(.WORD_WIDTH(8), .MAX_BURST(1), .TIMEOUT(0)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last),
    .req0_ready_o(req0_ready_c),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last),
    .req1_ready_o(req1_ready_c),
    .buf_valid_o(buf_valid_c), .buf_data_o(buf_data_c), .buf_ready_i(buf_ready),
    .grant_o(grant_c), .busy_o(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if (!manual) begin
      req0_valid = (q0.size() != 0);
      req0_data  = (q0.size() != 0) ? q0[0].d : 8'h00;
      req0_last  = (q0.size() != 0) ? q0[0].l : 1'b0;
      req1_valid = (q1.size() != 0);
      req1_data  = (q1.size() != 0) ? q1[0].d : 8'h00;
      req1_last  = (q1.size() != 0) ? q1[0].l : 1'b0;
    end
  endtask

  // Handshakes are sampled on the falling edge and retired just after the rise.
  task automatic cycle();
    logic pop0, pop1;
    @(negedge clk);
    pop0 = req0_valid & req0_ready_a;
    pop1 = req1_valid & req1_ready_a;
    if (buf_valid_a && buf_ready) log_q.push_back(buf_data_a);
    @(posedge clk);
    #1;
    if (pop0 && q0.size() != 0) void'(q0.pop_front());
    if (pop1 && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    manual  = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    cycle();
    cycle();
    reset_i = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    q0.push_back(w);
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    q1.push_back(w);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  logic [1:0] exp_g2 [20] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  logic [1:0] exp_g7 [5]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  initial begin
    // reset state
    do_reset();
    check("rst_grant", grant_a, 2'b00);
    check("rst_busy", busy_a, 1'b0);
    check("rst_bvalid", buf_valid_a, 1'b0);
    check("rst_bdata", buf_data_a, 8'h00);
    check("rst_rdy0", req0_ready_a, 1'b0);
    check("rst_rdy1", req1_ready_a, 1'b0);

    // 1: single producer, three-word burst
    push0(8'h11, 1'b0); push0(8'h22, 1'b0); push0(8'h33, 1'b1);
    drive();
    check("t1_decide_grant", grant_a, 2'b00);
    check("t1_decide_bvalid", buf_valid_a, 1'b0);
    cycle();
    check("t1_grant", grant_a, 2'b01);
    check("t1_busy", busy_a, 1'b1);
    check("t1_bdata", buf_data_a, 8'h11);
    for (int i = 0; i < 3; i++) cycle();
    check("t1_release", grant_a, 2'b00);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_log("t1_log");

    // 2: contention, alternating 4-word bursts
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push0(8'hA0 + 8'(i), (i % 4) == 3);
      push1(8'hB0 + 8'(i), (i % 4) == 3);
    end
    drive();
    for (int n = 0; n < 20; n++) begin
      cycle();
      check($sformatf("t2_grant_e%0d", n + 1), grant_a, exp_g2[n]);
    end
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
              8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    check_log("t2_log");

    // 3: 70-word stream split at 64
    do_reset();
    for (int i = 0; i < 70; i++) push0(8'(i), 1'b0);
    push1(8'hB0, 1'b0); push1(8'hB1, 1'b1);
    drive();
    for (int n = 1; n <= 76; n++) begin
      cycle();
      if (n == 64) check("t3_grant_e64", grant_a, 2'b01);
      if (n == 65) check("t3_grant_e65", grant_a, 2'b00);
      if (n == 66) check("t3_grant_e66", grant_a, 2'b10);
      if (n == 69) check("t3_grant_e69", grant_a, 2'b01);
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    for (int i = 64; i < 70; i++) exp_q.push_back(8'(i));
    check_log("t3_log");

    // 4: buffer full for 10 cycles mid-burst
    do_reset();
    for (int i = 0; i < 8; i++) push0(8'h40 + 8'(i), i == 7);
    drive();
    for (int i = 0; i < 4; i++) cycle();
    buf_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("t4_grant_s%0d", i), grant_a, 2'b01);
      check($sformatf("t4_rdy0_s%0d", i), req0_ready_a, 1'b0);
      check($sformatf("t4_rdy1_s%0d", i), req1_ready_a, 1'b0);
    end
    check("t4_burst_cnt", 32'(dut_a.r_burst_cnt), 3);
    check("t4_stall_len", log_q.size(), 3);
    buf_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("t4_release", grant_a, 2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
    check_log("t4_log");

    // 5: granted req1 goes quiet; TIMEOUT=8 vs TIMEOUT=0
    do_reset();
    push1(8'hC0, 1'b0); push1(8'hC1, 1'b0);
    drive();
    for (int i = 0; i < 10; i++) cycle();
    check("t5_hold_e10", grant_a, 2'b10);
    cycle();
    check("t5_timeout_e11", grant_a, 2'b00);
    check("t5_nto_grant_e11", grant_b, 2'b10);
    for (int i = 0; i < 30; i++) cycle();
    check("t5_nto_grant_e41", grant_b, 2'b10);
    check("t5_nto_busy_e41", busy_b, 1'b1);
    check("t5_len", log_q.size(), 2);

    // 6a: reset mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) push0(8'h60 + 8'(i), i == 5);
    drive();
    for (int i = 0; i < 3; i++) cycle();
    reset_i = 1'b1;
    #1;
    check("t6_rst_bvalid", buf_valid_a, 1'b0);
    check("t6_rst_rdy0", req0_ready_a, 1'b0);
    cycle();
    check("t6_rst_grant", grant_a, 2'b00);
    check("t6_rst_busy", busy_a, 1'b0);
    push1(8'hB0, 1'b0); push1(8'hB1, 1'b1);
    reset_i = 1'b0;
    drive();
    cycle();
    check("t6_prio_req0", grant_a, 2'b01);
    for (int i = 0; i < 4; i++) cycle();
    exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    check_log("t6_log");

    // 6b: en_i low mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) push0(8'h70 + 8'(i), i == 5);
    drive();
    for (int i = 0; i < 3; i++) cycle();
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t6b_bvalid_s%0d", i), buf_valid_a, 1'b0);
      check($sformatf("t6b_grant_s%0d", i), grant_a, 2'b01);
    end
    check("t6b_frozen_len", log_q.size(), 2);
    en_i = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("t6b_release", grant_a, 2'b00);
    exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    check_log("t6b_log");

    // 7: MAX_BURST=1 strict alternation; no decision while disabled
    do_reset();
    manual = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hAA; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hBB; req1_last = 1'b0;
    en_i = 1'b0;
    cycle();
    check("t7_en_off_grant", grant_c, 2'b00);
    en_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check($sformatf("t7_grant_s%0d", n + 1), grant_c, exp_g7[n]);
      if (n == 0) check("t7_data_req0", buf_data_c, 8'hAA);
      if (n == 2) check("t7_data_req1", buf_data_c, 8'hBB);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
